// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared widths, constants and types for the rv32i pipeline.
// Provides the canonical NOP encoding and the fetch-queue entry layout.
package rv32i_pkg;

  // Datapath width for PCs and instruction words
  localparam int DPW = 32;

  // ADDI x0, x0, 0 -- the architectural NOP used for pipeline bubbles
  localparam logic [DPW-1:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch result: the PC and the instruction fetched from it
  typedef struct packed {
    logic [DPW-1:0] pc;
    logic [DPW-1:0] instr;
  } fq_entry_t;

  // Advance a circular-buffer pointer; wraps naturally at the pointer width
  function automatic logic [7:0] fq_ptr_inc(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/rv32i_fq_storage.sv
// rv32i_fq_storage: DEPTH-entry register array for the fetch queue.
// One synchronous write port and one asynchronous read port. The array
// carries no reset: validity is tracked by the owner's pointers and count.
import rv32i_pkg::*;

module rv32i_fq_storage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem_q [DEPTH];

  // Capture the offered entry into the addressed slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head entry is visible combinationally so decode sees it without delay
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue: instruction buffer between fetch and decode.
// Holds up to DEPTH {pc, instr} pairs, drops everything on a redirect
// (flush_i) and shows a NOP bubble to decode whenever nothing is valid.
// Optional same-cycle enq->deq bypass when empty: define RV_FQ_BYPASS_EN.
import rv32i_pkg::*;

module rv32i_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int DPW   = rv32i_pkg::DPW
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       flush_i,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DPW-1:0]             enq_pc,
  input  logic [DPW-1:0]             enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [DPW-1:0]             deq_pc,
  output logic [DPW-1:0]             deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic      push;
  logic      pop;
  logic      bypass;
  logic      head_valid;
  fq_entry_t wr_entry;
  fq_entry_t rd_entry;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;

  // Ready depends only on occupancy, never on deq_ready, so no comb path
  // runs from decode back to fetch; a full queue refuses even while popping.
  assign enq_ready = !full;

  // A stored head is only offered when no redirect is in flight
  assign head_valid = !empty && !flush_i;

`ifdef RV_FQ_BYPASS_EN
  // Empty queue and decode ready: hand the fetch result straight through
  assign bypass = empty && enq_valid && deq_ready && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed in flight and never written
  assign push = enq_valid && enq_ready && !flush_i && !bypass;
  assign pop  = head_valid && deq_ready;

  assign wr_entry.pc    = enq_pc;
  assign wr_entry.instr = enq_instr;

  rv32i_fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Decode-side view: bypass entry, stored head, or a NOP bubble
  always_comb begin
    deq_valid = 1'b0;
    deq_pc    = '0;
    deq_instr = NOP_INSTR;
    if (bypass) begin
      deq_valid = 1'b1;
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end else if (head_valid) begin
      deq_valid = 1'b1;
      deq_pc    = rd_entry.pc;
      deq_instr = rd_entry.instr;
    end
  end

  // Next-state for pointers and occupancy; a redirect overrides everything
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; reset clears them immediately
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
